// File: rtl/simon_engine.sv
// simon_engine: memory-sequence game engine ("Simon").
//   Plays back a growing pseudo-random colour sequence on the LEDs, then
//   checks the player's button presses against it. The game is won once
//   MAX_LEN colours have been repeated correctly. It is lost on a wrong or
//   multi-button press, or when no press arrives within TIMEOUT_CYCLES.
// Ports:
//   clk    - clock; all state changes happen on the rising edge
//   reset  - synchronous, active-high reset
//   start  - level; begins a new game from IDLE, WIN or LOSE
//   seed   - LFSR seed, captured when a game starts (8'h00 is replaced by 8'h01)
//   btn    - player buttons, active-high, one bit per colour
//   led    - registered colour drive: one-hot during playback, echo of btn
//            while waiting for input, zero otherwise
//   state  - state code (IDLE=0 GEN=1 SHOW_ON=2 SHOW_GAP=3 WAIT_IN=4
//            WAIT_REL=5 WIN=6 LOSE=7)
//   round  - current sequence length
//   win    - high exactly while in WIN
//   lose   - high exactly while in LOSE
module simon_engine #(
  parameter int unsigned NUM_COLOURS    = 4,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned HOLD_CYCLES    = 1000,
  parameter int unsigned GAP_CYCLES     = 250,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  localparam int unsigned COL_W         = $clog2(NUM_COLOURS),
  localparam int unsigned LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             seed,
  input  logic [NUM_COLOURS-1:0] btn,
  output logic [NUM_COLOURS-1:0] led,
  output logic [2:0]             state,
  output logic [LEN_W-1:0]       round,
  output logic                   win,
  output logic                   lose
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GEN      = 3'd1;
  localparam logic [2:0] S_SHOW_ON  = 3'd2;
  localparam logic [2:0] S_SHOW_GAP = 3'd3;
  localparam logic [2:0] S_WAIT_IN  = 3'd4;
  localparam logic [2:0] S_WAIT_REL = 3'd5;
  localparam logic [2:0] S_WIN      = 3'd6;
  localparam logic [2:0] S_LOSE     = 3'd7;

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned T_MAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned T_MAX = (T_MAX_A > TIMEOUT_CYCLES) ? T_MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned TIM_W = $clog2(T_MAX + 1);

  localparam logic [TIM_W-1:0] HOLD_LAST    = TIM_W'(HOLD_CYCLES - 1);
  localparam logic [TIM_W-1:0] GAP_LAST     = TIM_W'(GAP_CYCLES - 1);
  localparam logic [TIM_W-1:0] TIMEOUT_LAST = TIM_W'(TIMEOUT_CYCLES - 1);

  logic [COL_W-1:0]       mem [MAX_LEN];
  logic [7:0]             lfsr;
  logic [LEN_W-1:0]       idx;
  logic [TIM_W-1:0]       timer;
  logic [NUM_COLOURS-1:0] btn_hist;

  logic [2:0]             state_n;
  logic [LEN_W-1:0]       round_n;
  logic [LEN_W-1:0]       idx_n;
  logic [LEN_W-1:0]       idx_inc;
  logic [TIM_W-1:0]       timer_n;
  logic [7:0]             lfsr_n;
  logic [NUM_COLOURS-1:0] led_n;
  logic [NUM_COLOURS-1:0] expected;
  logic                   mem_we;
  logic                   press;

  function automatic logic [NUM_COLOURS-1:0] onehot(input logic [COL_W-1:0] c);
    logic [NUM_COLOURS-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always_comb begin
    state_n  = state;
    round_n  = round;
    idx_n    = idx;
    timer_n  = timer;
    lfsr_n   = lfsr;
    mem_we   = 1'b0;
    idx_inc  = idx + LEN_W'(1);
    expected = onehot(mem[idx[IDX_W-1:0]]);
    // A press is a rising transition of the button bus as a whole, so a
    // button still held from before WAIT_IN never registers.
    press    = (btn != '0) && (btn_hist == '0);

    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_n = S_GEN;
          lfsr_n  = (seed == 8'h00) ? 8'h01 : seed;
          round_n = '0;
          idx_n   = '0;
          timer_n = '0;
        end
      end
      S_GEN: begin
        mem_we  = 1'b1;
        lfsr_n  = lfsr_step(lfsr);
        round_n = round + LEN_W'(1);
        idx_n   = '0;
        timer_n = '0;
        state_n = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (timer == HOLD_LAST) begin
          timer_n = '0;
          state_n = S_SHOW_GAP;
        end else begin
          timer_n = timer + TIM_W'(1);
        end
      end
      S_SHOW_GAP: begin
        if (timer == GAP_LAST) begin
          timer_n = '0;
          if (idx_inc == round) begin
            idx_n   = '0;
            state_n = S_WAIT_IN;
          end else begin
            idx_n   = idx_inc;
            state_n = S_SHOW_ON;
          end
        end else begin
          timer_n = timer + TIM_W'(1);
        end
      end
      S_WAIT_IN: begin
        if (press) begin
          timer_n = '0;
          state_n = (btn == expected) ? S_WAIT_REL : S_LOSE;
        end else if (timer == TIMEOUT_LAST) begin
          timer_n = '0;
          state_n = S_LOSE;
        end else begin
          timer_n = timer + TIM_W'(1);
        end
      end
      S_WAIT_REL: begin
        if (btn == '0) begin
          idx_n   = idx_inc;
          timer_n = '0;
          if (idx_inc < round) begin
            state_n = S_WAIT_IN;
          end else if (round == LEN_W'(MAX_LEN)) begin
            state_n = S_WIN;
          end else begin
            state_n = S_GEN;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // led is registered, so it is computed from the next-state values. On
    // the GEN -> SHOW_ON edge the entry being shown may be the one written
    // on that same edge, hence the bypass from the LFSR.
    led_n = '0;
    if (state_n == S_SHOW_ON) begin
      if (mem_we && (idx_n == round)) begin
        led_n = onehot(lfsr[COL_W-1:0]);
      end else begin
        led_n = onehot(mem[idx_n[IDX_W-1:0]]);
      end
    end else if ((state_n == S_WAIT_IN) || (state_n == S_WAIT_REL)) begin
      led_n = btn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      led      <= '0;
      round    <= '0;
      idx      <= '0;
      timer    <= '0;
      lfsr     <= 8'h01;
      btn_hist <= '0;
    end else begin
      state    <= state_n;
      led      <= led_n;
      round    <= round_n;
      idx      <= idx_n;
      timer    <= timer_n;
      lfsr     <= lfsr_n;
      btn_hist <= btn;
    end
  end

  // Sequence storage needs no reset: entries at or above round are never read.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[round[IDX_W-1:0]] <= lfsr[COL_W-1:0];
    end
  end

  assign win  = (state == S_WIN);
  assign lose = (state == S_LOSE);

endmodule

// File: doc/simon_engine.md
SIMON_ENGINE -- requirements
Module: simon_engine

Interface
REQ-001 Parameter NUM_COLOURS, default 4, number of colour channels; SHALL be 2, 4 or 8. COL_W = log2(NUM_COLOURS).
REQ-002 Parameter MAX_LEN, default 16, winning sequence length; SHALL be 1..32. LEN_W = bits needed to hold MAX_LEN.
REQ-003 Parameter HOLD_CYCLES, default 1000, cycles each colour is lit during playback; SHALL be >= 1.
REQ-004 Parameter GAP_CYCLES, default 250, dark cycles after each lit colour; SHALL be >= 1.
REQ-005 Parameter TIMEOUT_CYCLES, default 100000, maximum cycles allowed per player press; SHALL be >= 1.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  level; sampled in IDLE, WIN and LOSE to begin a new game.
REQ-009 seed  input  8  LFSR seed, captured when a game starts.
REQ-010 btn  input  NUM_COLOURS  player buttons, active-high, one bit per colour.
REQ-011 led  output  NUM_COLOURS  one-hot colour drive; all zero when dark.
REQ-012 state  output  3  state code: IDLE=0, GEN=1, SHOW_ON=2, SHOW_GAP=3, WAIT_IN=4, WAIT_REL=5, WIN=6, LOSE=7.
REQ-013 round  output  LEN_W  current sequence length.
REQ-014 win / lose  output  1 each  high exactly while in WIN / LOSE.

Function
REQ-015 The LFSR SHALL be an 8-bit Fibonacci register: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-016 On a start-triggered transition into GEN from IDLE, WIN or LOSE, lfsr SHALL load seed (8'h00 replaced by 8'h01), and round and idx SHALL clear to 0.
REQ-017 Sequence storage SHALL be MAX_LEN entries of COL_W bits; entries at or above round are don't-care.
REQ-018 GEN lasts 1 cycle: mem[round] <= lfsr[COL_W-1:0]; lfsr advances; round increments; idx <= 0; next state SHALL be SHOW_ON.
REQ-019 SHOW_ON lasts HOLD_CYCLES cycles with led = one-hot(mem[idx]); next state SHALL be SHOW_GAP.
REQ-020 SHOW_GAP lasts GAP_CYCLES cycles with led = 0; then idx++. If the new idx equals round: idx <= 0, timer cleared, go to WAIT_IN; otherwise go to SHOW_ON.
REQ-021 WAIT_IN: a press is the first cycle in which btn is nonzero after a cycle in which btn was zero. Buttons already held on entry SHALL NOT count until released.
REQ-022 Press with btn == one-hot(mem[idx]) SHALL go to WAIT_REL. Any other nonzero value, including multiple bits set, SHALL go to LOSE.
REQ-023 No press within TIMEOUT_CYCLES cycles of entering WAIT_IN SHALL go to LOSE; the timer restarts on every entry to WAIT_IN.
REQ-024 During WAIT_IN and WAIT_REL, led SHALL equal btn (echo).
REQ-025 WAIT_REL exits on the first cycle with btn == 0, and idx++. If the new idx < round, go to WAIT_IN. Else if round == MAX_LEN, go to WIN. Otherwise go to GEN.
REQ-026 In WIN and LOSE, led = 0 and round holds its value. start high SHALL begin a new game (REQ-016); otherwise the state is held.
REQ-027 IDLE: led = 0; start high SHALL go to GEN next cycle.
REQ-028 All outputs SHALL be registered or decoded from registered state only; no combinational path from btn to win/lose.
REQ-029 Timer and counters SHALL saturate/reset per state; no wrap-around is permitted to cause a spurious transition.

Reset
REQ-030 On reset: state=IDLE, led=0, round=0, idx=0, timer=0, lfsr=8'h01, win=lose=0, button-history register=0.
REQ-031 reset SHALL take priority over every transition, including mid-playback and mid-press.

Verification (NUM_COLOURS=4, MAX_LEN=3, HOLD=4, GAP=2, TIMEOUT=20, seed=8'h01)
REQ-032 Playback timing: start at cycle 0 -> state=GEN at cycle 1; led=4'b0010 cycles 2-5; led=0 cycles 6-7; state=WAIT_IN at cycle 8 with round=1.
REQ-033 Full win: player echoes 0010; 0010,0100; 0010,0100,0001, releasing each time -> win=1, round=3, led=0.
REQ-034 Wrong or multi press: round 1, press 4'b0110 -> lose=1 one cycle later; start -> GEN with round cleared to 0 and then 1.
REQ-035 Timeout: enter WAIT_IN, no press for 20 cycles -> state=LOSE; press on cycle 19 -> accepted.
REQ-036 Held button: btn=0010 held from SHOW_GAP into WAIT_IN -> no press counted until btn=0 then 0010.
REQ-037 Reset mid-SHOW_ON -> next cycle state=IDLE, led=0, round=0.
